// File: rtl/uart_rx_sampler.sv
// 16x-oversampling UART receiver: 2-flop synchronizer, 7/8/9 majority vote, sticky status flags.
// Optional parity stage is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_sampler #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx_clk_en,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       rx_ready_clear,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic       rx_meta;
  logic       rx_s;
  logic [2:0] state;
  logic [3:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift_q;
  logic       s7;
  logic       s8;
  logic       armed;
  logic       vote;
  logic [7:0] data_word;
  logic       stop_tick;
  logic       set_ready;
  logic       set_fe;
  logic       set_ovr;
  logic       set_pe;

  // NOTE: synchronizer flops reset to the idle line level so reset release never looks like a start edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign vote = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);

  // Bits arrive LSB first and are shifted in from the top, so short words sit in the upper bits.
  assign data_word = shift_q >> (8 - DATA_BITS);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      bit_idx <= 3'd0;
      shift_q <= 8'd0;
      s7      <= 1'b1;
      s8      <= 1'b1;
      armed   <= 1'b1;
    end else if (rx_clk_en) begin
      cnt <= cnt + 4'd1;
      if (cnt == 4'd7) s7 <= rx_s;
      if (cnt == 4'd8) s8 <= rx_s;
      case (state)
        IDLE: begin
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= START;
            cnt   <= 4'd0;
          end
        end
        START: begin
          if (cnt == 4'd9 && vote) begin
            state <= IDLE;
          end else if (cnt == 4'd15) begin
            state   <= DATA;
            bit_idx <= 3'd0;
          end
        end
        DATA: begin
          if (cnt == 4'd9) shift_q <= {vote, shift_q[7:1]};
          if (cnt == 4'd15) begin
            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == 4'd15) state <= STOP;
        end
`endif
        STOP: begin
          // Leave at mid stop bit to give half a bit of slack before the next start edge.
          if (cnt == 4'd9) begin
            state <= IDLE;
            if (!vote) armed <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stop_tick = rx_clk_en && (state == STOP) && (cnt == 4'd9);
  assign set_ready = stop_tick & vote;
  assign set_fe    = stop_tick & ~vote;
  assign set_ovr   = set_ready & rx_ready;

`ifdef UART_RX_PARITY_EN
  logic parity_bad;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      parity_bad <= 1'b0;
    end else if (rx_clk_en && state == PARITY && cnt == 4'd9) begin
      parity_bad <= vote ^ (^data_word) ^ PARITY_ODD;
    end
  end

  assign set_pe = set_ready & parity_bad;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) parity_err <= 1'b0;
    else            parity_err <= set_pe | (parity_err & ~rx_ready_clear);
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
  assign set_pe            = 1'b0;
  assign parity_err        = set_pe;
`endif

  // A set event wins over a coincident clear for its own flag only.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_data   <= 8'd0;
      rx_ready  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (set_ready) rx_data <= data_word;
      rx_ready  <= set_ready | (rx_ready  & ~rx_ready_clear);
      frame_err <= set_fe    | (frame_err & ~rx_ready_clear);
      overrun   <= set_ovr   | (overrun   & ~rx_ready_clear);
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: table-driven frames with a scoreboard queue plus
// hand-written glitch, framing-error/break, mid-frame reset and (with UART_RX_PARITY_EN) parity sequences.
module tb_uart_rx_sampler;

  localparam bit PARITY_ODD = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       ready;
    logic       ovr;
    logic       fe;
    logic       pe;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       clr;
    exp_t       exp;
  } vec_t;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       rx_clk_en;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_ready_clear;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t vecs[4];

  uart_rx_sampler #(.DATA_BITS(8), .PARITY_ODD(PARITY_ODD)) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .rx_clk_en      (rx_clk_en),
    .rx             (rx),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .rx_ready_clear (rx_ready_clear),
    .frame_err      (frame_err),
    .overrun        (overrun),
    .parity_err     (parity_err)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Oversample tick: high for one sys_clk cycle out of every two.
  initial begin
    rx_clk_en = 1'b0;
    forever begin
      @(negedge sys_clk);
      rx_clk_en = ~rx_clk_en;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk_exp(logic [7:0] d, logic r, logic o, logic f, logic p);
    exp_t e;
    e.data  = d;
    e.ready = r;
    e.ovr   = o;
    e.fe    = f;
    e.pe    = p;
    return e;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, req);
    end
  endtask

  task automatic wait_tick();
    do @(posedge sys_clk); while (rx_clk_en !== 1'b1);
  endtask

  task automatic send_bit(input logic b);
    #1 rx = b;
    repeat (16) wait_tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) $display("note: parity bit ignored");
`endif
    send_bit(stop);
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ PARITY_ODD;
  endfunction

  task automatic compare_out(input string tag);
    exp_t e;
    @(negedge sys_clk);
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
    end else begin
      n_cmp--;
      e = sb.pop_front();
      check({tag, ".rx_data"},    rx_data,           e.data);
      check({tag, ".rx_ready"},   {7'd0, rx_ready},  {7'd0, e.ready});
      check({tag, ".overrun"},    {7'd0, overrun},   {7'd0, e.ovr});
      check({tag, ".frame_err"},  {7'd0, frame_err}, {7'd0, e.fe});
      check({tag, ".parity_err"}, {7'd0, parity_err},{7'd0, e.pe});
    end
  endtask

  task automatic pulse_clear(input string tag);
    @(negedge sys_clk);
    rx_ready_clear = 1'b1;
    @(negedge sys_clk);
    rx_ready_clear = 1'b0;
    check({tag, ".clr.rx_ready"},   {7'd0, rx_ready},   8'd0);
    check({tag, ".clr.overrun"},    {7'd0, overrun},    8'd0);
    check({tag, ".clr.frame_err"},  {7'd0, frame_err},  8'd0);
    check({tag, ".clr.parity_err"}, {7'd0, parity_err}, 8'd0);
  endtask

  initial begin
    vecs[0] = '{data: 8'h55, stop: 1'b1, clr: 1'b1, exp: mk_exp(8'h55, 1'b1, 1'b0, 1'b0, 1'b0)};
    vecs[1] = '{data: 8'hA3, stop: 1'b1, clr: 1'b1, exp: mk_exp(8'hA3, 1'b1, 1'b0, 1'b0, 1'b0)};
    vecs[2] = '{data: 8'h12, stop: 1'b1, clr: 1'b0, exp: mk_exp(8'h12, 1'b1, 1'b0, 1'b0, 1'b0)};
    vecs[3] = '{data: 8'h34, stop: 1'b1, clr: 1'b1, exp: mk_exp(8'h34, 1'b1, 1'b1, 1'b0, 1'b0)};

    sys_rst_n      = 1'b0;
    rx             = 1'b1;
    rx_ready_clear = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("reset.rx_data",    rx_data,            8'd0);
    check("reset.rx_ready",   {7'd0, rx_ready},   8'd0);
    check("reset.overrun",    {7'd0, overrun},    8'd0);
    check("reset.frame_err",  {7'd0, frame_err},  8'd0);
    check("reset.parity_err", {7'd0, parity_err}, 8'd0);
    sys_rst_n = 1'b1;
    repeat (32) wait_tick();

    // Table: two cleared frames, then two back-to-back frames producing an overrun.
    for (int i = 0; i < 4; i++) begin
      sb.push_back(vecs[i].exp);
      send_frame(vecs[i].data, good_par(vecs[i].data), vecs[i].stop);
      compare_out($sformatf("vec%0d", i));
      if (vecs[i].clr) pulse_clear($sformatf("vec%0d", i));
      send_bit(1'b1);
    end

    // Short start-bit glitch must be rejected.
    #1 rx = 1'b0;
    repeat (4) wait_tick();
    #1 rx = 1'b1;
    repeat (32) wait_tick();
    @(negedge sys_clk);
    check("glitch.rx_ready",  {7'd0, rx_ready},  8'd0);
    check("glitch.frame_err", {7'd0, frame_err}, 8'd0);
    sb.push_back(mk_exp(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0));
    send_frame(8'h3C, good_par(8'h3C), 1'b1);
    compare_out("after_glitch");
    pulse_clear("after_glitch");
    send_bit(1'b1);

    // Framing error followed by a break held low; no retrigger until the line returns high.
    sb.push_back(mk_exp(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0));
    send_frame(8'h00, good_par(8'h00), 1'b0);
    repeat (32) wait_tick();
    compare_out("frame_err");
    send_bit(1'b1);
    sb.push_back(mk_exp(8'h81, 1'b1, 1'b0, 1'b1, 1'b0));
    send_frame(8'h81, good_par(8'h81), 1'b1);
    compare_out("after_break");
    send_bit(1'b1);

    // Reset after the 4th data bit of 0xF0 with flags still set.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("midrst.rx_data",   rx_data,            8'd0);
    check("midrst.rx_ready",  {7'd0, rx_ready},   8'd0);
    check("midrst.frame_err", {7'd0, frame_err},  8'd0);
    check("midrst.overrun",   {7'd0, overrun},    8'd0);
    rx = 1'b1;
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (32) wait_tick();
    sb.push_back(mk_exp(8'h0F, 1'b1, 1'b0, 1'b0, 1'b0));
    send_frame(8'h0F, good_par(8'h0F), 1'b1);
    compare_out("after_reset");
    pulse_clear("after_reset");
    send_bit(1'b1);

`ifdef UART_RX_PARITY_EN
    sb.push_back(mk_exp(8'h07, 1'b1, 1'b0, 1'b0, 1'b1));
    send_frame(8'h07, 1'b0, 1'b1);
    compare_out("parity_bad");
    pulse_clear("parity_bad");
    send_bit(1'b1);
    sb.push_back(mk_exp(8'h07, 1'b1, 1'b0, 1'b0, 1'b0));
    send_frame(8'h07, 1'b1, 1'b1);
    compare_out("parity_good");
    pulse_clear("parity_good");
`endif

    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- 16x-oversampling UART receive engine; the receive-direction counterpart of the team's UART transmit path.
- Sits between the `rx` pin and the host logic, driven by the `rx_clk_en` tick from `uart_clock_generator` (one pulse per 1/16 bit).
- Recovers 8N1 frames (optional parity) using majority-vote mid-bit sampling.
- Reports a received byte plus framing, overrun and parity status to the host through a ready/clear handshake.

Parameters:
- DATA_BITS, 8, data bits per frame; legal values 5..8; LSB first on the line; unused upper `rx_data` bits read 0.
- PARITY_ODD, 0, used only with UART_RX_PARITY_EN: 0 = even parity, 1 = odd parity.

Ports:
- sys_clk  input  1  system clock; all logic is on the rising edge.
- sys_rst_n  input  1  reset: one clock; asynchronous assert, active-low.
- rx_clk_en  input  1  single-cycle oversample tick, 16 per bit period.
- rx  input  1  serial line, asynchronous to sys_clk, idle high.
- rx_data  output  8  last accepted byte.
- rx_ready  output  1  byte available; sticky.
- rx_ready_clear  input  1  single-cycle host acknowledge.
- frame_err  output  1  sticky: stop bit sampled low.
- overrun  output  1  sticky: new byte accepted while rx_ready=1.
- parity_err  output  1  sticky: parity mismatch; tied 0 without the macro.

Behaviour:
- Reset (async, sys_rst_n=0):
  - rx_data=0; rx_ready, frame_err, overrun and parity_err = 0.
  - State=IDLE, armed=1.
  - Synchronizer flops reset to 1.
- rx is passed through a 2-flop synchronizer to give rx_s; rx_s is the only internal view of the line.
- All state, counters and sampling advance only on cycles with rx_clk_en=1; everything holds otherwise.
- Sample counter: 4 bits, wraps 15->0.
- Majority vote: the bit value is the majority of rx_s taken at counts 7, 8 and 9; it is decided on the count-9 tick.
- IDLE:
  - Tick with rx_s=1 sets armed=1.
  - Tick with rx_s=0 and armed=1 -> START, count=0.
- START:
  - Count 9: vote=1 -> IDLE (glitch rejected, no flags change).
  - Count 15 -> DATA, bit_idx=0.
- DATA:
  - Count 9: shift the vote into the shift register, LSB first.
  - Count 15: if bit_idx==DATA_BITS-1 -> PARITY (macro) or STOP; else bit_idx+1.
- PARITY (macro only):
  - Count 9: compare the vote with the data XOR (inverted if PARITY_ODD=1).
  - Count 15 -> STOP.
- STOP, count 9:
  - vote=1: load rx_data and set rx_ready. If rx_ready was already 1, also set overrun; the new byte overwrites rx_data. A parity mismatch sets parity_err; the byte is still delivered.
  - vote=0: set frame_err; rx_data and rx_ready unchanged; armed=0 so a held-low line (break) does not retrigger.
  - In both cases -> IDLE at count 9, leaving half a bit of resync slack.
- Latency: flags and rx_data update on the sys_clk edge of the stop-bit count-9 tick. This is 2 sys_clk cycles of synchronizer delay plus about 9.5 bit periods after the start edge.
- rx_ready_clear=1 clears rx_ready, overrun, frame_err and parity_err on the next edge.
- If a set event coincides with rx_ready_clear, the set wins for that flag and the other flags clear.
- Reset mid-frame aborts immediately with no partial-byte delivery; reception resumes from IDLE.

Optional Feature:
- Macro name: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP; the frame is 1 + DATA_BITS + 1 + 1 bits.
  - parity_err is live as described above.
- When undefined:
  - No PARITY state and no parity logic; the frame is 1 + DATA_BITS + 1 bits.
  - parity_err is constant 0 and PARITY_ODD is ignored.

Test Plan:
- Send 0x55 then 0xA3 at 16 ticks/bit, pulsing rx_ready_clear after each -> rx_data=0x55 then 0xA3; rx_ready pulses twice; all error flags 0.
- rx low for 4 ticks, then high -> state returns to IDLE; rx_ready=0, frame_err=0; a following 0x3C is received correctly.
- Frame 0x00 with the stop bit driven low, line held low 3 bit times -> frame_err=1, rx_ready=0, no retrigger until rx is high; the next 0x81 is received correctly.
- Send 0x12 and 0x34 without clearing -> rx_data=0x34, rx_ready=1, overrun=1; assert rx_ready_clear -> all flags 0.
- Assert sys_rst_n=0 after the 4th data bit of 0xF0 -> all outputs 0 immediately; a subsequent 0x0F is received correctly.
- With UART_RX_PARITY_EN and PARITY_ODD=0, send 0x07 with parity bit 0 -> rx_data=0x07, rx_ready=1, parity_err=1. Same frame with parity bit 1 -> parity_err=0.
